stall_mgmt_ctrl: RTL and testbench

Global stall/flush controller at the receiving end of the buffer-full interface.
- Collects the full indication from every pipeline buffer, an external stall request and a flush request.
- Drives the single registered stall and flush lines broadcast back to all buffer stages.
- Applies release hysteresis so buffers are not toggled every cycle, and flags stalls that never resolve.

---
 rtl/stall_mgmt_pkg.sv | 17 +
 rtl/stall_timeout_ctr.sv | 43 ++++
 rtl/stall_mgmt_ctrl.sv | 161 ++++++++++++++++
 tb/tb_stall_mgmt_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/stall_mgmt_pkg.sv
// Shared constants for the stall/flush controller and the buffer stages it serves.
// Holds the FSM state encoding, the default timing parameters and the buffer data width.
package stall_mgmt_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  localparam int DEF_HOLD_CYCLES  = 2;
  localparam int DEF_FLUSH_CYCLES = 1;
  localparam int DEF_TIMEOUT      = 1024;
  localparam int DATA_W           = 32;

endpackage

// File: rtl/stall_timeout_ctr.sv
// Saturating count of consecutive stalled cycles.
// Emits one registered pulse when the count first reaches TIMEOUT; it re-arms only after stall drops.
module stall_timeout_ctr
  import stall_mgmt_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic stall_in,
  output logic timeout_pulse
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!stall_in) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + CW'(1);
    end
    // Only the transition into the saturated value fires.
    pulse_d = (cnt_d == LIMIT) && (cnt_q != LIMIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign timeout_pulse = pulse_q;

endmodule

// File: rtl/stall_mgmt_ctrl.sv
// Global stall/flush controller: merges buffer-full flags, external stall and flush requests
// into registered stall/flush broadcasts with release hysteresis. Build option STALL_PERF_CNT_EN adds perf counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | pipeline flowing, stall=0 flush=0
// ST_STALL | a stall cause is active, stall=1
// ST_HOLD  | causes cleared, stall held for HOLD_CYCLES more cycles
// ST_FLUSH | flush=1 for FLUSH_CYCLES (extended by further requests)
module stall_mgmt_ctrl
  import stall_mgmt_pkg::*;
#(
  parameter int NUM_BUFS     = 4,
  parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BUFS-1:0] buf_full,
  input  logic                ext_stall_req,
  input  logic                flush_req,
  output logic                stall,
  output logic                flush,
  output logic                stall_timeout,
  output logic [1:0]          state_out
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0]         stall_cycle_cnt,
  output logic [15:0]         flush_cnt
`endif
);

  localparam int  HW      = $clog2(HOLD_CYCLES + 2);
  localparam int  FW      = $clog2(FLUSH_CYCLES + 1);
  localparam bit  HOLD_EN = (HOLD_CYCLES > 0);
  localparam logic [HW-1:0] HOLD_LOAD  = HOLD_EN ? HW'(HOLD_CYCLES - 1) : '0;
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);

  state_e        state_q, state_d;
  logic [HW-1:0] hold_tmr_q, hold_tmr_d;
  logic [FW-1:0] flush_tmr_q, flush_tmr_d;
  logic          stall_q, stall_d;
  logic          flush_q, flush_d;
  logic          cause;

  assign cause = (|buf_full) | ext_stall_req;

  always_comb begin
    state_d     = state_q;
    hold_tmr_d  = hold_tmr_q;
    flush_tmr_d = flush_tmr_q;
    case (state_q)
      ST_RUN: begin
        if (flush_req) begin
          state_d     = ST_FLUSH;
          flush_tmr_d = FLUSH_LOAD;
        end else if (cause) begin
          state_d = ST_STALL;
        end
      end
      ST_STALL: begin
        if (flush_req) begin
          state_d     = ST_FLUSH;
          flush_tmr_d = FLUSH_LOAD;
        end else if (!cause) begin
          if (HOLD_EN) begin
            state_d    = ST_HOLD;
            hold_tmr_d = HOLD_LOAD;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_HOLD: begin
        if (flush_req) begin
          state_d     = ST_FLUSH;
          flush_tmr_d = FLUSH_LOAD;
        end else if (cause) begin
          state_d = ST_STALL;
        end else if (hold_tmr_q == '0) begin
          state_d = ST_RUN;
        end else begin
          hold_tmr_d = hold_tmr_q - HW'(1);
        end
      end
      ST_FLUSH: begin
        // Causes are ignored here; RUN picks them up on the following edge.
        if (flush_req) begin
          flush_tmr_d = FLUSH_LOAD;
        end else if (flush_tmr_q == '0) begin
          state_d = ST_RUN;
        end else begin
          flush_tmr_d = flush_tmr_q - FW'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase
    stall_d = (state_d == ST_STALL) || (state_d == ST_HOLD);
    flush_d = (state_d == ST_FLUSH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      hold_tmr_q  <= '0;
      flush_tmr_q <= '0;
      stall_q     <= 1'b0;
      flush_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_tmr_q  <= hold_tmr_d;
      flush_tmr_q <= flush_tmr_d;
      stall_q     <= stall_d;
      flush_q     <= flush_d;
    end
  end

  stall_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk           (clk),
    .reset         (reset),
    .stall_in      (stall_q),
    .timeout_pulse (stall_timeout)
  );

  assign stall     = stall_q;
  assign flush     = flush_q;
  assign state_out = state_q;

`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cyc_q, stall_cyc_d;
  logic [15:0] flush_ent_q, flush_ent_d;

  always_comb begin
    stall_cyc_d = stall_cyc_q;
    flush_ent_d = flush_ent_q;
    if (stall_q && (stall_cyc_q != '1)) begin
      stall_cyc_d = stall_cyc_q + 32'd1;
    end
    if ((state_d == ST_FLUSH) && (state_q != ST_FLUSH) && (flush_ent_q != '1)) begin
      flush_ent_d = flush_ent_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cyc_q <= '0;
      flush_ent_q <= '0;
    end else begin
      stall_cyc_q <= stall_cyc_d;
      flush_ent_q <= flush_ent_d;
    end
  end

  assign stall_cycle_cnt = stall_cyc_q;
  assign flush_cnt       = flush_ent_q;
`endif

endmodule

// File: tb/tb_stall_mgmt_ctrl.sv
// Directed self-checking bench for stall_mgmt_ctrl (HOLD_CYCLES=2, FLUSH_CYCLES=1, TIMEOUT=8).
// Perf counter checks are active when STALL_PERF_CNT_EN is defined.
module tb_stall_mgmt_ctrl;
  import stall_mgmt_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] buf_full;
  logic       ext_stall_req;
  logic       flush_req;
  logic       stall, flush, stall_timeout;
  logic [1:0] state_out;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cycle_cnt;
  logic [15:0] flush_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // Running model of the perf counters, fed from expected values only.
  logic   prev_stall = 1'b0;
  state_e prev_state = ST_RUN;
  int     exp_sc     = 0;
  int     exp_fc     = 0;

  always #5 clk = ~clk;

  stall_mgmt_ctrl #(
    .NUM_BUFS     (4),
    .HOLD_CYCLES  (2),
    .FLUSH_CYCLES (1),
    .TIMEOUT      (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .buf_full      (buf_full),
    .ext_stall_req (ext_stall_req),
    .flush_req     (flush_req),
    .stall         (stall),
    .flush         (flush),
    .stall_timeout (stall_timeout),
    .state_out     (state_out)
`ifdef STALL_PERF_CNT_EN
    ,
    .stall_cycle_cnt (stall_cycle_cnt),
    .flush_cnt       (flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then check all outputs against the expected state.
  task automatic step(input string tag, input state_e exp_st, input logic exp_to);
    logic es, ef;
    @(posedge clk);
    #1;
    es = (exp_st == ST_STALL) || (exp_st == ST_HOLD);
    ef = (exp_st == ST_FLUSH);
    exp_sc = exp_sc + (prev_stall ? 1 : 0);
    if (ef && (prev_state != ST_FLUSH)) exp_fc++;
    chk({tag, ".state"}, 32'(state_out), 32'(exp_st));
    chk({tag, ".stall"}, 32'(stall), 32'(es));
    chk({tag, ".flush"}, 32'(flush), 32'(ef));
    chk({tag, ".tmo"},   32'(stall_timeout), 32'(exp_to));
`ifdef STALL_PERF_CNT_EN
    chk({tag, ".scnt"}, stall_cycle_cnt, 32'(exp_sc));
    chk({tag, ".fcnt"}, 32'(flush_cnt), 32'(exp_fc));
`endif
    prev_stall = es;
    prev_state = exp_st;
  endtask

  initial begin
    reset = 1'b1;
    buf_full = 4'b0000;
    ext_stall_req = 1'b0;
    flush_req = 1'b0;
    #12;
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.flush", 32'(flush), 32'd0);
    chk("rst.tmo",   32'(stall_timeout), 32'd0);
    chk("rst.state", 32'(state_out), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) step("idle", ST_RUN, 1'b0);

    // Single buffer full for four edges, then hysteresis release.
    buf_full = 4'b0100;
    for (int i = 0; i < 4; i++) step("bf2", ST_STALL, 1'b0);
    buf_full = 4'b0000;
    step("hold1", ST_HOLD, 1'b0);
    step("hold2", ST_HOLD, 1'b0);
    step("rel",   ST_RUN,  1'b0);

    // Cause returns while holding: back to STALL with no gap.
    buf_full = 4'b0001;
    step("re.stall", ST_STALL, 1'b0);
    buf_full = 4'b0000;
    step("re.hold", ST_HOLD, 1'b0);
    buf_full = 4'b0001;
    step("re.back", ST_STALL, 1'b0);
    buf_full = 4'b0000;
    step("re.h1", ST_HOLD, 1'b0);
    step("re.h2", ST_HOLD, 1'b0);
    step("re.run", ST_RUN, 1'b0);

    // Flush pulse while all buffers full.
    buf_full = 4'b1111;
    step("fl.stall", ST_STALL, 1'b0);
    flush_req = 1'b1;
    step("fl.flush", ST_FLUSH, 1'b0);
    flush_req = 1'b0;
    step("fl.exit", ST_RUN, 1'b0);
    step("fl.restall", ST_STALL, 1'b0);
    buf_full = 4'b0000;
    step("fl.h1", ST_HOLD, 1'b0);
    step("fl.h2", ST_HOLD, 1'b0);
    step("fl.run", ST_RUN, 1'b0);

    // Flush beats a simultaneous cause; a held request extends the flush.
    flush_req = 1'b1;
    ext_stall_req = 1'b1;
    step("fx.win", ST_FLUSH, 1'b0);
    ext_stall_req = 1'b0;
    step("fx.ext", ST_FLUSH, 1'b0);
    flush_req = 1'b0;
    step("fx.exit", ST_RUN, 1'b0);
    step("fx.idle", ST_RUN, 1'b0);

    // Persistent external stall: one timeout pulse after the 8th stalled cycle.
    ext_stall_req = 1'b1;
    for (int i = 1; i <= 14; i++) step("tmo", ST_STALL, (i == 9));

    // Asynchronous reset between edges while stalled.
    #3;
    reset = 1'b1;
    #1;
    chk("arst.stall", 32'(stall), 32'd0);
    chk("arst.state", 32'(state_out), 32'd0);
    chk("arst.flush", 32'(flush), 32'd0);
    chk("arst.tmo",   32'(stall_timeout), 32'd0);
`ifdef STALL_PERF_CNT_EN
    chk("arst.scnt", stall_cycle_cnt, 32'd0);
    chk("arst.fcnt", 32'(flush_cnt), 32'd0);
`endif
    prev_stall = 1'b0;
    prev_state = ST_RUN;
    exp_sc = 0;
    exp_fc = 0;
    ext_stall_req = 1'b0;
    #2;
    reset = 1'b0;
    step("post.rst1", ST_RUN, 1'b0);
    step("post.rst2", ST_RUN, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
